// File: rtl/fetch_controller_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | fetch_controller_if : fetch-stage control, redirect and debug-load bus   |
// | Revision: 1.0                                                            |
// +-------------------------------------------------------------------------+
interface fetch_controller_if #(
  parameter int XLEN               = 64,
  parameter int INSTRUCTION_LENGTH = XLEN / 2
);
  logic                          dbg_mode;
  logic                          dbg_wr_en_in;
  logic [XLEN-1:0]               dbg_addr_in;
  logic [INSTRUCTION_LENGTH-1:0] dbg_instr_in;
  logic                          dbg_wr_en;
  logic [XLEN-1:0]               dbg_addr;
  logic [INSTRUCTION_LENGTH-1:0] dbg_instr;
  logic                          stall;
  logic                          redirect_valid;
  logic [XLEN-1:0]               redirect_target;
  logic [XLEN-1:0]               PC_out;
  logic                          fetch_valid;
  logic                          flush;
  logic                          misaligned;
  logic [1:0]                    state;
  logic [XLEN-1:0]               fetched_count;

  modport master (
    output dbg_mode, dbg_wr_en_in, dbg_addr_in, dbg_instr_in,
           stall, redirect_valid, redirect_target,
    input  dbg_wr_en, dbg_addr, dbg_instr, PC_out, fetch_valid,
           flush, misaligned, state, fetched_count
  );

  modport slave (
    input  dbg_mode, dbg_wr_en_in, dbg_addr_in, dbg_instr_in,
           stall, redirect_valid, redirect_target,
    output dbg_wr_en, dbg_addr, dbg_instr, PC_out, fetch_valid,
           flush, misaligned, state, fetched_count
  );
endinterface
`default_nettype wire

// File: rtl/fetch_controller.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | fetch_controller : PC sequencing and instruction-memory debug arbitration|
// | Revision: 1.0                                                            |
// +-------------------------------------------------------------------------+
module fetch_controller #(
  parameter int              XLEN               = 64,
  parameter int              INSTRUCTION_LENGTH = XLEN / 2,
  parameter logic [XLEN-1:0] RESET_VECTOR       = '0
) (
  input  wire               clk,
  input  wire               rst,
  fetch_controller_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] cnt_q, cnt_d;
  logic            flush_q, flush_d;
  logic            mis_q, mis_d;
  logic            fetch_valid_q;
  logic            fetch_valid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_VECTOR;
      cnt_q         <= '0;
      flush_q       <= 1'b0;
      mis_q         <= 1'b0;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      cnt_q         <= cnt_d;
      flush_q       <= flush_d;
      mis_q         <= mis_d;
      fetch_valid_q <= fetch_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    flush_d = 1'b0;
    mis_d   = mis_q;
    case (state_q)
      IDLE: begin
        pc_d    = RESET_VECTOR;
        state_d = bus.dbg_mode ? LOAD : RUN;
      end
      LOAD: begin
        pc_d = RESET_VECTOR;
        if (!bus.dbg_mode) state_d = RUN;
      end
      RUN: begin
        // Priority: debug takeover, misaligned redirect, redirect, stall, advance.
        if (bus.dbg_mode) begin
          state_d = LOAD;
          pc_d    = RESET_VECTOR;
          flush_d = 1'b1;
        end else if (bus.redirect_valid) begin
          flush_d = 1'b1;
          if (bus.redirect_target[1:0] != 2'b00) begin
            state_d = HALT;
            mis_d   = 1'b1;
          end else begin
            pc_d = bus.redirect_target;
          end
        end else if (!bus.stall) begin
          pc_d  = pc_q + XLEN'(4);
          cnt_d = cnt_q + XLEN'(1);
        end
      end
      HALT: begin
        if (bus.dbg_mode) begin
          state_d = LOAD;
          pc_d    = RESET_VECTOR;
          mis_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fetch_valid_d = (state_d == RUN);

  // Debug write path is intentionally combinational so LOAD-state writes land same cycle.
  assign bus.dbg_wr_en     = bus.dbg_wr_en_in && (state_q == LOAD);
  assign bus.dbg_addr      = bus.dbg_addr_in;
  assign bus.dbg_instr     = bus.dbg_instr_in;
  assign bus.PC_out        = pc_q;
  assign bus.fetch_valid   = fetch_valid_q;
  assign bus.flush         = flush_q;
  assign bus.misaligned    = mis_q;
  assign bus.state         = state_q;
  assign bus.fetched_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_controller.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_fetch_controller : directed + randomized bench for fetch_controller   |
// | Revision: 1.0                                                            |
// +-------------------------------------------------------------------------+
module tb_fetch_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   cmp_en  = 1'b0;

  always #5 clk = ~clk;

  fetch_controller_if #(.XLEN(64), .INSTRUCTION_LENGTH(32)) bus ();

  fetch_controller #(
    .XLEN(64),
    .INSTRUCTION_LENGTH(32),
    .RESET_VECTOR(64'd0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Reference model: states 0=IDLE 1=LOAD 2=RUN 3=HALT
  int          m_state = 0;
  logic [63:0] m_pc    = 64'd0;
  logic [63:0] m_cnt   = 64'd0;
  bit          m_fv    = 1'b0;
  bit          m_flush = 1'b0;
  bit          m_mis   = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = 0; m_pc = 64'd0; m_cnt = 64'd0;
      m_fv = 1'b0; m_flush = 1'b0; m_mis = 1'b0;
    end else begin
      bit nf;
      nf = 1'b0;
      if (m_state == 0) begin
        m_pc    = 64'd0;
        m_state = bus.dbg_mode ? 1 : 2;
      end else if (m_state == 1) begin
        m_pc = 64'd0;
        if (!bus.dbg_mode) m_state = 2;
      end else if (m_state == 2) begin
        if (bus.dbg_mode) begin
          m_state = 1; m_pc = 64'd0; nf = 1'b1;
        end else if (bus.redirect_valid && (bus.redirect_target % 4 != 0)) begin
          m_state = 3; m_mis = 1'b1; nf = 1'b1;
        end else if (bus.redirect_valid) begin
          m_pc = bus.redirect_target; nf = 1'b1;
        end else if (!bus.stall) begin
          m_pc  = m_pc + 64'd4;
          m_cnt = m_cnt + 64'd1;
        end
      end else begin
        if (bus.dbg_mode) begin
          m_state = 1; m_pc = 64'd0; m_mis = 1'b0;
        end
      end
      m_flush = nf;
      m_fv    = (m_state == 2);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("state",       64'(bus.state),         64'(m_state));
      check("PC_out",      bus.PC_out,             m_pc);
      check("fetch_valid", 64'(bus.fetch_valid),   64'(m_fv));
      check("flush",       64'(bus.flush),         64'(m_flush));
      check("misaligned",  64'(bus.misaligned),    64'(m_mis));
      check("count",       bus.fetched_count,      m_cnt);
      check("dbg_wr_en",   64'(bus.dbg_wr_en),     64'(bus.dbg_wr_en_in && m_state == 1));
      check("dbg_addr",    bus.dbg_addr,           bus.dbg_addr_in);
      check("dbg_instr",   64'(bus.dbg_instr),     64'(bus.dbg_instr_in));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    bus.dbg_mode = 1'b0; bus.dbg_wr_en_in = 1'b0;
    bus.dbg_addr_in = '0; bus.dbg_instr_in = '0;
    bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_target = '0;
  endtask

  task automatic do_reset(input bit dbg);
    tick();
    bus.dbg_mode = dbg;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [63:0] saved_cnt;

  initial begin
    clear_inputs();
    #1 rst = 1'b1;
    cmp_en = 1'b1;
    #20 rst = 1'b0;

    // Sequence 1: boot straight into RUN
    do_reset(1'b0);
    check("s1 idle state", 64'(bus.state), 64'd0);
    check("s1 idle pc",    bus.PC_out, 64'd0);
    tick(); check("s1 run state", 64'(bus.state), 64'd2);
    check("s1 pc0", bus.PC_out, 64'd0);
    check("s1 fv",  64'(bus.fetch_valid), 64'd1);
    tick(); check("s1 pc4", bus.PC_out, 64'd4);
    tick(); check("s1 pc8", bus.PC_out, 64'd8);
    tick(); check("s1 pc12", bus.PC_out, 64'd12);
    check("s1 cnt3", bus.fetched_count, 64'd3);

    // Sequence 2: debug load then run
    do_reset(1'b1);
    tick(); check("s2 load", 64'(bus.state), 64'd1);
    bus.dbg_wr_en_in = 1'b1; bus.dbg_addr_in = 64'd0; bus.dbg_instr_in = 32'h0050_0093;
    #1 check("s2 wr0", 64'(bus.dbg_wr_en), 64'd1);
    tick();
    bus.dbg_addr_in = 64'd4; bus.dbg_instr_in = 32'h0010_0113;
    #1 check("s2 wr1 data", 64'(bus.dbg_instr), 64'h0010_0113);
    tick();
    bus.dbg_wr_en_in = 1'b0; bus.dbg_mode = 1'b0;
    tick(); check("s2 run pc0", bus.PC_out, 64'd0);
    bus.dbg_wr_en_in = 1'b1;
    #1 check("s2 run wr dropped", 64'(bus.dbg_wr_en), 64'd0);
    tick(); check("s2 pc4", bus.PC_out, 64'd4);
    bus.dbg_wr_en_in = 1'b0;

    // Sequence 3: stall holds PC and count
    tick(); tick(); tick();
    check("s3 pc10", bus.PC_out, 64'h10);
    saved_cnt = bus.fetched_count;
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); check("s3 stall pc", bus.PC_out, 64'h10);
      check("s3 stall cnt", bus.fetched_count, m_cnt);
    end
    bus.stall = 1'b0;
    tick(); check("s3 pc14", bus.PC_out, 64'h14);

    // Sequence 4: redirect beats stall
    tick(); tick(); tick();
    check("s4 pc20", bus.PC_out, 64'h20);
    saved_cnt = bus.fetched_count;
    bus.redirect_valid = 1'b1; bus.redirect_target = 64'h100; bus.stall = 1'b1;
    tick(); check("s4 pc100", bus.PC_out, 64'h100);
    check("s4 flush", 64'(bus.flush), 64'd1);
    check("s4 cnt held", bus.fetched_count - saved_cnt, 64'd0);
    bus.redirect_valid = 1'b0; bus.stall = 1'b0;
    tick(); check("s4 pc104", bus.PC_out, 64'h104);
    check("s4 flush clr", 64'(bus.flush), 64'd0);

    // Sequence 5: misaligned redirect halts
    bus.redirect_valid = 1'b1; bus.redirect_target = 64'h102;
    tick(); check("s5 halt", 64'(bus.state), 64'd3);
    check("s5 mis", 64'(bus.misaligned), 64'd1);
    check("s5 fv", 64'(bus.fetch_valid), 64'd0);
    check("s5 pc frozen", bus.PC_out, 64'h104);
    bus.redirect_valid = 1'b0;
    tick(); check("s5 still halt", bus.PC_out, 64'h104);
    bus.dbg_mode = 1'b1;
    tick(); check("s5 load", 64'(bus.state), 64'd1);
    check("s5 mis clr", 64'(bus.misaligned), 64'd0);
    check("s5 pc0", bus.PC_out, 64'd0);

    // Sequence 6: PC wrap, then async reset mid-cycle
    bus.dbg_mode = 1'b0;
    tick();
    bus.redirect_valid = 1'b1; bus.redirect_target = 64'hFFFF_FFFF_FFFF_FFFC;
    tick(); check("s6 pc top", bus.PC_out, 64'hFFFF_FFFF_FFFF_FFFC);
    bus.redirect_valid = 1'b0;
    tick(); check("s6 wrap", bus.PC_out, 64'd0);
    tick();
    rst = 1'b1;
    #1;
    check("s6 async state", 64'(bus.state), 64'd0);
    check("s6 async pc", bus.PC_out, 64'd0);
    check("s6 async cnt", bus.fetched_count, 64'd0);
    check("s6 async fv", 64'(bus.fetch_valid), 64'd0);
    #1 rst = 1'b0;

    // Randomized phase against the model
    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom_range(0, 15) == 0) bus.dbg_mode = ~bus.dbg_mode;
      bus.stall          = ($urandom_range(0, 3) == 0);
      bus.redirect_valid = ($urandom_range(0, 5) == 0);
      bus.redirect_target = {$urandom, $urandom};
      if ($urandom_range(0, 7) != 0) bus.redirect_target[1:0] = 2'b00;
      if ($urandom_range(0, 9) == 0) bus.redirect_target = 64'hFFFF_FFFF_FFFF_FFF8;
      bus.dbg_wr_en_in = $urandom_range(0, 1) == 1;
      bus.dbg_addr_in  = {$urandom, $urandom};
      bus.dbg_instr_in = $urandom;
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        #2 rst = 1'b0;
      end
    end

    tick();
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
